// File: rtl/jt89_pkg.sv
// Shared constants, register encodings and level tables for the JT89 sound generator.
package jt89_pkg;

  localparam int unsigned DIN_W     = 8;
  localparam int unsigned CH_W      = 10;
  localparam int unsigned SND_W     = 12;
  localparam int unsigned PER_W     = 10;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned ATT_W     = 4;
  localparam int unsigned PRESC_W   = 4;
  localparam int unsigned NCNT_W    = 6;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned NREG_W    = 3;
  localparam int unsigned NUM_TONES = 3;
  localparam int unsigned NUM_CH    = 4;

  localparam logic [PRESC_W-1:0] PRESC_LAST  = 4'hF;
  localparam logic [CNT_W-1:0]   ZERO_RELOAD = 11'd1024;
  localparam logic [LFSR_W-1:0]  LFSR_SEED   = 16'h8000;
  localparam logic [1:0]         NF_TONE2    = 2'd3;

  typedef enum logic [1:0] {
    CH_TONE0 = 2'd0,
    CH_TONE1 = 2'd1,
    CH_TONE2 = 2'd2,
    CH_NOISE = 2'd3
  } chan_e;

  typedef enum logic {
    REG_TONE = 1'b0,
    REG_VOL  = 1'b1
  } reg_e;

  typedef struct packed {
    chan_e chan;
    reg_e  typ;
  } latch_t;

  // 2 dB attenuation steps; step 15 is silence.
  function automatic logic [CH_W-1:0] att_amp(input logic [ATT_W-1:0] att);
    case (att)
      4'd0:    att_amp = 10'd511;
      4'd1:    att_amp = 10'd406;
      4'd2:    att_amp = 10'd322;
      4'd3:    att_amp = 10'd256;
      4'd4:    att_amp = 10'd203;
      4'd5:    att_amp = 10'd161;
      4'd6:    att_amp = 10'd128;
      4'd7:    att_amp = 10'd102;
      4'd8:    att_amp = 10'd81;
      4'd9:    att_amp = 10'd64;
      4'd10:   att_amp = 10'd51;
      4'd11:   att_amp = 10'd40;
      4'd12:   att_amp = 10'd32;
      4'd13:   att_amp = 10'd26;
      4'd14:   att_amp = 10'd20;
      default: att_amp = 10'd0;
    endcase
  endfunction

  function automatic logic signed [CH_W-1:0] chan_level(input logic bit_on,
                                                        input logic [ATT_W-1:0] att);
    logic signed [CH_W-1:0] amp;
    amp        = signed'(att_amp(att));
    chan_level = bit_on ? amp : -amp;
  endfunction

  // Shift-clock half period in ticks is mask+1: 16, 32 or 64.
  function automatic logic [NCNT_W-1:0] nf_mask(input logic [1:0] nf);
    case (nf)
      2'd0:    nf_mask = 6'h0F;
      2'd1:    nf_mask = 6'h1F;
      default: nf_mask = 6'h3F;
    endcase
  endfunction

endpackage

// File: rtl/jt89_tone.sv
// Square-wave tone divider: reloads from the period on underflow and flips its output bit.
module jt89_tone
  import jt89_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [PER_W-1:0] period,
  output logic             sq
);

  logic [CNT_W-1:0] count;
  logic             toggle_c;

  always_comb begin
    toggle_c = tick & (count <= CNT_W'(1));
  end

  // Period changes are picked up only at the next reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      sq    <= 1'b0;
    end else if (toggle_c) begin
      count <= (period == '0) ? ZERO_RELOAD : CNT_W'(period);
      sq    <= ~sq;
    end else if (tick) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/jt89.sv
// JT89 programmable sound generator: register file, three tones, LFSR noise and mixer.
module jt89
  import jt89_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  input  logic                     wr_n,
  input  logic [DIN_W-1:0]         din,
  output logic signed [CH_W-1:0]   ch0,
  output logic signed [CH_W-1:0]   ch1,
  output logic signed [CH_W-1:0]   ch2,
  output logic signed [CH_W-1:0]   noise,
  output logic signed [SND_W-1:0]  sound
);

  logic                 wr_last;
  logic                 wr_c;
  latch_t               lat;
  chan_e                w_chan_c;
  reg_e                 w_typ_c;
  logic                 reseed_c;
  logic [PER_W-1:0]     period [NUM_TONES];
  logic [ATT_W-1:0]     att [NUM_CH];
  logic [NREG_W-1:0]    nreg;
  logic [PRESC_W-1:0]   presc;
  logic                 tick_c;
  logic [NUM_TONES-1:0] sq;
  logic [NCNT_W-1:0]    ncnt;
  logic                 nclk;
  logic [LFSR_W-1:0]    lfsr;
  logic                 sq2_last;
  logic                 ntog_c;
  logic                 shift_c;
  logic                 fb_c;

  // One write per falling strobe, both edges seen on enabled cycles only.
  assign wr_c = clken & ~wr_n & wr_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_last <= 1'b1;
    end else if (clken) begin
      wr_last <= wr_n;
    end
  end

  // Latch bytes carry their own target; data bytes reuse the latched one.
  always_comb begin
    w_chan_c = lat.chan;
    w_typ_c  = lat.typ;
    if (din[7]) begin
      w_chan_c = chan_e'(din[6:5]);
      w_typ_c  = reg_e'(din[4]);
    end
    reseed_c = wr_c & (w_typ_c == REG_TONE) & (w_chan_c == CH_NOISE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat  <= '{chan: CH_TONE0, typ: REG_TONE};
      nreg <= '0;
      for (int unsigned i = 0; i < NUM_TONES; i++) period[i] <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) att[i] <= '1;
    end else if (wr_c) begin
      if (din[7]) lat <= '{chan: w_chan_c, typ: w_typ_c};
      if (w_typ_c == REG_VOL)        att[w_chan_c]          <= din[3:0];
      else if (w_chan_c == CH_NOISE) nreg                   <= din[2:0];
      else if (din[7])               period[w_chan_c][3:0]  <= din[3:0];
      else                           period[w_chan_c][9:4]  <= din[5:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clken) begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign tick_c = clken & (presc == PRESC_LAST);

  for (genvar i = 0; i < NUM_TONES; i++) begin : g_tone
    jt89_tone u_tone (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_c),
      .period (period[i]),
      .sq     (sq[i])
    );
  end

  // Tone-2 toggles are seen through a history bit, one enabled cycle late.
  always_comb begin
    if (nreg[1:0] == NF_TONE2) begin
      ntog_c = clken & (sq[NUM_TONES-1] ^ sq2_last);
    end else begin
      ntog_c = tick_c & ((ncnt & nf_mask(nreg[1:0])) == nf_mask(nreg[1:0]));
    end
    shift_c = ntog_c & ~nclk;
    fb_c    = nreg[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ncnt     <= '0;
      nclk     <= 1'b0;
      lfsr     <= LFSR_SEED;
      sq2_last <= 1'b0;
    end else begin
      if (tick_c) ncnt <= ncnt + NCNT_W'(1);
      if (ntog_c) nclk <= ~nclk;
      if (clken)  sq2_last <= sq[NUM_TONES-1];
      if (reseed_c)     lfsr <= LFSR_SEED;
      else if (shift_c) lfsr <= {fb_c, lfsr[LFSR_W-1:1]};
    end
  end

  // Mixer: sound trails the channel outputs by one enabled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch0   <= '0;
      ch1   <= '0;
      ch2   <= '0;
      noise <= '0;
      sound <= '0;
    end else if (clken) begin
      ch0   <= chan_level(sq[0], att[0]);
      ch1   <= chan_level(sq[1], att[1]);
      ch2   <= chan_level(sq[2], att[2]);
      noise <= chan_level(lfsr[0], att[3]);
      sound <= SND_W'(ch0) + SND_W'(ch1) + SND_W'(ch2) + SND_W'(noise);
    end
  end

endmodule

// File: tb/tb_jt89.sv
// Randomized self-checking bench for jt89 against a cycle-level behavioural model.
module tb_jt89;

  logic              clk = 1'b0;
  logic              rst;
  logic              clken;
  logic              wr_n;
  logic [7:0]        din;
  logic signed [9:0] ch0, ch1, ch2, noise;
  logic signed [11:0] sound;

  jt89 dut (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .wr_n  (wr_n),
    .din   (din),
    .ch0   (ch0),
    .ch1   (ch1),
    .ch2   (ch2),
    .noise (noise),
    .sound (sound)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  int amp_t [16] = '{511, 406, 322, 256, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 0};

  // model state
  int m_per [3];
  int m_cnt [3];
  int m_sq  [3];
  int m_att [4];
  int m_ch  [4];
  int m_nreg, m_lch, m_lvol, m_wlast, m_en_cnt, m_ticks, m_nclk, m_tog2_prev, m_lfsr, m_sound;

  // half-period watcher
  int wsel = -1;
  int wexp, wprev, ntrans, last_t;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_per[i] = 0; m_cnt[i] = 0; m_sq[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_att[i] = 15; m_ch[i] = 0;
    end
    m_nreg = 0; m_lch = 0; m_lvol = 0; m_wlast = 1; m_en_cnt = 0; m_ticks = 0;
    m_nclk = 0; m_tog2_prev = 0; m_lfsr = 'h8000; m_sound = 0;
  endfunction

  function automatic void model_step(input bit en, input bit wn, input logic [7:0] d);
    int tick, rate, ntog, tog2, fb, amp;
    if (!en) return;
    m_sound = m_ch[0] + m_ch[1] + m_ch[2] + m_ch[3];
    for (int i = 0; i < 3; i++) begin
      amp = amp_t[m_att[i]];
      m_ch[i] = m_sq[i] ? amp : -amp;
    end
    amp = amp_t[m_att[3]];
    m_ch[3] = (m_lfsr & 1) ? amp : -amp;
    tick = ((m_en_cnt % 16) == 15);
    m_en_cnt++;
    rate = 16 << (m_nreg & 3);
    if ((m_nreg & 3) == 3) ntog = m_tog2_prev;
    else ntog = tick && ((m_ticks % rate) == rate - 1);
    if (tick) m_ticks++;
    tog2 = 0;
    if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cnt[i] <= 1) begin
          m_cnt[i] = (m_per[i] == 0) ? 1024 : m_per[i];
          m_sq[i] = !m_sq[i];
          if (i == 2) tog2 = 1;
        end else begin
          m_cnt[i]--;
        end
      end
    end
    m_tog2_prev = tog2;
    if (ntog) begin
      if (!m_nclk) begin
        fb = (m_nreg & 4) ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
      end
      m_nclk = !m_nclk;
    end
    if (!wn && m_wlast) begin
      if (d[7]) begin
        m_lch = d[6:5];
        m_lvol = d[4];
      end
      if (m_lvol) m_att[m_lch] = d[3:0];
      else if (m_lch == 3) begin
        m_nreg = d[2:0];
        m_lfsr = 'h8000;
      end else if (d[7]) m_per[m_lch] = (m_per[m_lch] & 'h3F0) | d[3:0];
      else m_per[m_lch] = (m_per[m_lch] & 'hF) | (int'(d[5:0]) << 4);
    end
    m_wlast = wn;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ch0", int'(ch0), m_ch[0]);
    check("ch1", int'(ch1), m_ch[1]);
    check("ch2", int'(ch2), m_ch[2]);
    check("noise", int'(noise), m_ch[3]);
    check("sound", int'(sound), m_sound);
  end

  task automatic cycle(input bit en, input bit wn, input logic [7:0] d);
    int v;
    clken = en; wr_n = wn; din = d;
    @(posedge clk);
    #1;
    ncyc++;
    if (rst) model_step(en, wn, d);
    else model_reset();
    if (wsel >= 0) begin
      v = (wsel == 0) ? int'(ch0) : int'(ch1);
      if (v != 0) begin
        if (wprev != 0 && ((v > 0) != (wprev > 0))) begin
          if (ntrans > 0) check("half_period", ncyc - last_t, wexp);
          ntrans++;
          last_t = ncyc;
        end
        wprev = v;
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    cycle(1'b1, 1'b0, d);
    cycle(1'b1, 1'b1, d);
  endtask

  task automatic watch(input int sel, input int exp_iv);
    wsel = sel; wexp = exp_iv; wprev = 0; ntrans = 0; last_t = 0;
  endtask

  // Called just after a sampled edge; asserts reset between edges.
  task automatic pulse_reset();
    #1;
    clken = 1'b0; wr_n = 1'b1;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_ch0", int'(ch0), 0);
    check("rst_ch1", int'(ch1), 0);
    check("rst_ch2", int'(ch2), 0);
    check("rst_noise", int'(noise), 0);
    check("rst_sound", int'(sound), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    ncyc = 0;
  endtask

  initial begin
    logic [7:0] d;
    int pos_seen, k;
    rst = 1'b0; clken = 1'b0; wr_n = 1'b1; din = '0;
    model_reset();
    @(posedge clk);
    pulse_reset();

    // ch0 period 16 at full volume: 256-cycle half periods
    write_byte(8'h80); write_byte(8'h01); write_byte(8'h90);
    watch(0, 256);
    repeat (1100) cycle(1'b1, 1'b1, 8'h00);
    check("ch0_transitions", ntrans, 5);
    check("ch0_mag", iabs(int'(ch0)), 511);
    wsel = -1;

    // ch1 period 0 reloads 1024: 16384-cycle half periods, then mute
    pulse_reset();
    write_byte(8'hB0); write_byte(8'hA0); write_byte(8'h00);
    watch(1, 16384);
    repeat (32850) cycle(1'b1, 1'b1, 8'h00);
    check("ch1_transitions", ntrans, 3);
    wsel = -1;
    write_byte(8'hBF);
    repeat (2) cycle(1'b1, 1'b1, 8'h00);
    check("ch1_muted", int'(ch1), 0);

    // all channels full volume, same phase, before the first tick
    pulse_reset();
    write_byte(8'h90); write_byte(8'hB0); write_byte(8'hD0); write_byte(8'hF0);
    repeat (4) cycle(1'b1, 1'b1, 8'h00);
    check("sound_min", int'(sound), -2044);
    check("noise_seed_level", int'(noise), -511);

    // white noise NF=0 after reseed
    write_byte(8'hE4);
    check("noise_reseed", int'(noise), -511);
    pos_seen = 0;
    for (int i = 0; i < 8500; i++) begin
      cycle(1'b1, 1'b1, 8'h00);
      if (noise > 0) pos_seen = 1;
    end
    check("noise_moves", pos_seen, 1);

    // strobe held low: one write only; strobes with clken=0 ignored
    repeat (40) cycle(1'b1, 1'b0, 8'h9A);
    repeat (10) cycle(1'b1, 1'b0, 8'h9C);
    repeat (3) cycle(1'b1, 1'b1, 8'h00);
    check("held_strobe_vol", iabs(int'(ch0)), 51);
    cycle(1'b0, 1'b0, 8'h90); cycle(1'b0, 1'b1, 8'h90);
    cycle(1'b0, 1'b0, 8'h90); cycle(1'b0, 1'b1, 8'h90);
    repeat (3) cycle(1'b1, 1'b1, 8'h00);
    check("gated_strobe_vol", iabs(int'(ch0)), 51);

    // reset mid-tone: everything silent until volumes are rewritten
    write_byte(8'h80); write_byte(8'h02); write_byte(8'h90);
    repeat (300) cycle(1'b1, 1'b1, 8'h00);
    pulse_reset();
    repeat (300) cycle(1'b1, 1'b1, 8'h00);
    check("post_rst_ch0", int'(ch0), 0);
    check("post_rst_ch1", int'(ch1), 0);
    check("post_rst_ch2", int'(ch2), 0);
    check("post_rst_noise", int'(noise), 0);

    // randomized register traffic with random clock enables
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        d = 8'($urandom);
        if (!d[7] && $urandom_range(0, 3) != 0) d[5:1] = '0;
        k = $urandom_range(1, 3);
        repeat (k) cycle($urandom_range(0, 3) != 0, 1'b0, d);
        cycle(1'b1, 1'b1, d);
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'b1, 8'($urandom));
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jt89.md
JT89 -- requirements
Module: jt89

Interface
REQ-001 Reset is asynchronous and active-low; all state is clocked on the rising edge of the single clock.
REQ-002 clk  input  1  system clock, rising edge.
REQ-003 rst  input  1  asynchronous active-low reset (port name kept per codebase).
REQ-004 clken  input  1  clock enable; all internal timing advances only in cycles where clken=1.
REQ-005 wr_n  input  1  active-low write strobe.
REQ-006 din  input  8  write data byte.
REQ-007 ch0, ch1, ch2  output  10 signed  tone channel outputs, registered.
REQ-008 noise  output  10 signed  noise channel output, registered.
REQ-009 sound  output  12 signed  mixed output, registered.

Function
REQ-010 A write SHALL be accepted in a cycle with clken=1 when wr_n=0 and wr_n was 1 at the previous clken=1 cycle: one write per falling strobe.
REQ-011 Latch byte (din[7]=1): din[6:5] selects the channel (0-2 tone, 3 noise), din[4] selects the register type (1 volume, 0 tone/noise), din[3:0] is written to the low 4 bits of that register, and channel/type are latched.
REQ-012 Data byte (din[7]=0): din[5:0] SHALL be written to tone period bits [9:4] of the latched channel if it is a tone register; for a volume or noise target, din[3:0] is written to that register.
REQ-013 A prescaler SHALL produce one tick every 16 clken cycles.
REQ-014 Tone counter: on each tick, if count<=1 then reload with the period (period 0 reloads 1024) and toggle the square bit, else decrement; half-period = 16*N clken cycles.
REQ-015 Noise register: bit2 FB (1 white, 0 periodic), bits[1:0] NF; NF=0/1/2 shift clock toggles every 16/32/64 ticks, NF=3 uses channel-2 square-bit toggles.
REQ-016 16-bit LFSR SHALL shift right on each rising edge of the noise shift clock; feedback = bit0 XOR bit3 (white) or bit0 (periodic); noise bit = bit0.
REQ-017 Any write to the noise register SHALL reseed the LFSR to 0x8000.
REQ-018 Attenuation 0..15 in 2 dB steps maps to amplitude 511,406,322,256,203,161,128,102,81,64,51,40,32,26,20,0.
REQ-019 Each channel output = +amplitude when its bit is 1, -amplitude when 0.
REQ-020 sound SHALL be the registered sum of ch0+ch1+ch2+noise, one clk after the channel outputs; the maximum magnitude of 2044 fits, so no saturation is applied.
REQ-021 Outputs SHALL update only on clken=1 cycles; with clken=0 all state holds.
REQ-022 A period or volume write takes effect at the next reload or output update; it SHALL NOT restart the counter.

Reset
REQ-023 In reset: periods 0, counters 0, square bits 0, attenuations 0xF, noise register 0, LFSR 0x8000, prescaler 0, latch = channel 0 tone, write-edge history = 1.
REQ-024 In reset ch0..ch2, noise and sound SHALL be 0; release at any time SHALL restart from this state.

Structure
REQ-025 Package jt89_pkg SHALL hold the attenuation table, the register-type/channel encodings and the prescaler/noise rate constants.
REQ-026 Tone generation SHALL be a sub-module jt89_tone instantiated three times; noise, register file and mixer SHALL stay in the top module.

Verification
REQ-027 Reset, then write 0x80,0x01,0x90 -> ch0 toggles sign every 16*16=256 clken cycles between +511 and -511.
REQ-028 Period 0 on ch1 at volume 0 -> half-period 16384 clk; vol 0xF (0xBF) -> ch1=0.
REQ-029 Write 0xE4 (white, NF=0) -> LFSR reseeded to 0x8000, shifts every 32 ticks, sequence matches a model using the bit0^bit3 tap.
REQ-030 All channels at vol 0 with equal phase -> sound=+2044 or -2044, never wrapping.
REQ-031 wr_n held low for many cycles -> exactly one write; pulsing wr_n with clken=0 -> no write.
REQ-032 Assert rst mid-tone -> all outputs 0 asynchronously; after release ch0..noise stay 0 until volumes are rewritten.
